// File: rtl/disp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : disp_seq_pkg
// Brief   : Shared types, message constants and helpers for display_sequencer.
// Revision: 1.0
// ============================================================================
package disp_seq_pkg;

    localparam int SEL_W = 8;

    localparam logic [SEL_W-1:0] MSG_CNT_A = 8'd0;
    localparam logic [SEL_W-1:0] MSG_CNT_B = 8'd7;

    typedef enum logic [0:0] {
        AUTO   = 1'b0,
        MANUAL = 1'b1
    } state_t;

    // A counter message only counts when it exists in the configured message set.
    function automatic logic is_counter_msg(input logic [SEL_W-1:0] sel, input int num_msg);
        return ((sel == MSG_CNT_A) && (int'(MSG_CNT_A) < num_msg)) ||
               ((sel == MSG_CNT_B) && (int'(MSG_CNT_B) < num_msg));
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_sequencer_btn_edge.sv
`default_nettype none
// ============================================================================
// Module  : btn_edge
// Brief   : Button synchronizer chain followed by a rising-edge event detector.
// Revision: 1.0
// ============================================================================
module btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic btn_async,
    output logic btn_event
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   last_level;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_chain <= '0;
            last_level <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], btn_async};
            last_level <= sync_chain[SYNC_STAGES-1];
        end
    end

    // A held button yields exactly one event on its synchronized rising edge.
    assign btn_event = sync_chain[SYNC_STAGES-1] & ~last_level;

endmodule
`default_nettype wire

// File: rtl/display_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : display_sequencer
// Brief   : Message selector for the seven-segment multiplexer: dwell-timed
//           auto cycling or button stepping, plus BCD counter gating.
// Revision: 1.0
// ============================================================================
module display_sequencer
    import disp_seq_pkg::*;
#(
    parameter int NUM_MSG     = 8,
    parameter int TICK_DIV    = 500000,
    parameter int DWELL_TICKS = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             BtnNext,
    input  logic             BtnPrev,
    input  logic             BtnMode,
    output logic [SEL_W-1:0] Selector,
    output logic             CountEnable,
    output logic             CountClear,
    output logic             AutoMode,
    output logic             Tick
);

    localparam int DIV_W   = cnt_width(TICK_DIV);
    localparam int DWELL_W = cnt_width(DWELL_TICKS);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_MSG - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [SEL_W-1:0]   sel_inc;
    logic [SEL_W-1:0]   sel_dec;
    state_t             state;
    state_t             state_nxt;
    logic               next_ev;
    logic               prev_ev;
    logic               mode_ev;

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_next (
        .Clock(Clock), .Reset(Reset), .btn_async(BtnNext), .btn_event(next_ev)
    );
    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_prev (
        .Clock(Clock), .Reset(Reset), .btn_async(BtnPrev), .btn_event(prev_ev)
    );
    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_mode (
        .Clock(Clock), .Reset(Reset), .btn_async(BtnMode), .btn_event(mode_ev)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_cnt <= '0;
            Tick    <= 1'b0;
        end else begin
            Tick    <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign sel_inc = (Selector == SEL_LAST) ? '0 : Selector + 1'b1;
    assign sel_dec = (Selector == '0) ? SEL_LAST : Selector - 1'b1;

    // Priority: mode toggle, then a lone step button, then dwell expiry.
    always_comb begin
        state_nxt = state;
        sel_nxt   = Selector;
        dwell_nxt = dwell_cnt;
        if (mode_ev) begin
            state_nxt = (state == AUTO) ? MANUAL : AUTO;
            dwell_nxt = '0;
        end else if (next_ev ^ prev_ev) begin
            sel_nxt   = next_ev ? sel_inc : sel_dec;
            dwell_nxt = '0;
        end else if ((state == AUTO) && Tick) begin
            if (dwell_cnt == DWELL_LAST) begin
                sel_nxt   = sel_inc;
                dwell_nxt = '0;
            end else begin
                dwell_nxt = dwell_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= AUTO;
            Selector    <= '0;
            dwell_cnt   <= '0;
            CountEnable <= 1'b0;
            CountClear  <= 1'b0;
        end else begin
            state       <= state_nxt;
            Selector    <= sel_nxt;
            dwell_cnt   <= dwell_nxt;
            CountEnable <= is_counter_msg(sel_nxt, NUM_MSG);
            // Clear on any change into a counter message, including 7 -> 0.
            CountClear  <= is_counter_msg(sel_nxt, NUM_MSG) && (sel_nxt != Selector);
        end
    end

    assign AutoMode = (state == AUTO);

endmodule
`default_nettype wire

// File: tb/tb_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_display_sequencer
// Brief   : Scoreboard bench for display_sequencer against a reference model.
// Revision: 1.0
// ============================================================================
module tb_display_sequencer;

    localparam int NMSG  = 8;
    localparam int TDIV  = 4;
    localparam int DWELL = 3;
    localparam int SYNC  = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       BtnNext = 1'b0;
    logic       BtnPrev = 1'b0;
    logic       BtnMode = 1'b0;
    logic [7:0] Selector;
    logic       CountEnable;
    logic       CountClear;
    logic       AutoMode;
    logic       Tick;

    display_sequencer #(
        .NUM_MSG(NMSG), .TICK_DIV(TDIV), .DWELL_TICKS(DWELL), .SYNC_STAGES(SYNC)
    ) dut (
        .Clock(Clock), .Reset(Reset), .BtnNext(BtnNext), .BtnPrev(BtnPrev),
        .BtnMode(BtnMode), .Selector(Selector), .CountEnable(CountEnable),
        .CountClear(CountClear), .AutoMode(AutoMode), .Tick(Tick)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [7:0] sel;
        logic       auto_m;
        logic       en;
        logic       clr;
        logic       tick;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    passed = 0;

    // Reference model state, in terms of messages, ticks counted and edges elapsed.
    int       m_sel, m_dwell, m_n;
    bit       m_auto, m_en, m_clr, m_tick;
    bit [2:0] h_next, h_prev, h_mode;

    function automatic bit is_cnt(input int s);
        return (s == 0) || (s == 7);
    endfunction

    // A level sampled at edge k becomes a press event acted on at edge k+2.
    task automatic model_step();
        bit nev, pev, mev, tick_in;
        int new_sel;
        if (Reset) begin
            m_sel = 0; m_dwell = 0; m_n = 0; m_auto = 1'b1;
            m_en = 1'b0; m_clr = 1'b0; m_tick = 1'b0;
            h_next = '0; h_prev = '0; h_mode = '0;
        end else begin
            nev = h_next[1] & ~h_next[2];
            pev = h_prev[1] & ~h_prev[2];
            mev = h_mode[1] & ~h_mode[2];
            tick_in = m_tick;
            new_sel = m_sel;
            if (mev) begin
                m_auto  = !m_auto;
                m_dwell = 0;
            end else if (nev != pev) begin
                new_sel = nev ? (m_sel + 1) % NMSG : (m_sel + NMSG - 1) % NMSG;
                m_dwell = 0;
            end else if (m_auto && tick_in) begin
                m_dwell++;
                if (m_dwell == DWELL) begin
                    new_sel = (m_sel + 1) % NMSG;
                    m_dwell = 0;
                end
            end
            m_clr  = is_cnt(new_sel) && (new_sel != m_sel);
            m_en   = is_cnt(new_sel);
            m_sel  = new_sel;
            m_n++;
            m_tick = (m_n % TDIV) == 0;
            h_next = {h_next[1:0], BtnNext};
            h_prev = {h_prev[1:0], BtnPrev};
            h_mode = {h_mode[1:0], BtnMode};
        end
        exp_q.push_back('{sel: 8'(m_sel), auto_m: m_auto, en: m_en, clr: m_clr, tick: m_tick});
    endtask

    initial begin
        forever begin
            @(posedge Clock);
            model_step();
        end
    end

    initial begin
        snap_t e;
        snap_t got;
        forever begin
            @(negedge Clock);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = '{sel: Selector, auto_m: AutoMode, en: CountEnable, clr: CountClear, tick: Tick};
                checks++;
                if (got !== e)
                    $display("FAIL outputs t=%0t got sel=%0d auto=%b en=%b clr=%b tick=%b, expected sel=%0d auto=%b en=%b clr=%b tick=%b",
                             $time, got.sel, got.auto_m, got.en, got.clr, got.tick,
                             e.sel, e.auto_m, e.en, e.clr, e.tick);
                else
                    passed++;
            end
        end
    end

    task automatic press(input int which, input int hold);
        case (which)
            0:       BtnNext = 1'b1;
            1:       BtnPrev = 1'b1;
            default: BtnMode = 1'b1;
        endcase
        repeat (hold) @(negedge Clock);
        BtnNext = 1'b0; BtnPrev = 1'b0; BtnMode = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        $display("FAIL %s wait expired at t=%0t, condition required within budget", what, $time);
    endtask

    initial begin
        int guard;
        repeat (5) @(negedge Clock);
        Reset = 1'b0;
        repeat (110) @(negedge Clock);

        press(2, 3);
        repeat (100) @(negedge Clock);

        guard = 0;
        while (m_sel != 0 && guard < 10) begin
            press(0, 2);
            guard++;
        end
        if (m_sel != 0) timeout_fail("navigate_to_0");

        BtnPrev = 1'b1;
        repeat (20) @(negedge Clock);
        BtnPrev = 1'b0;
        repeat (5) @(negedge Clock);
        press(0, 2);

        BtnNext = 1'b1; BtnPrev = 1'b1;
        repeat (3) @(negedge Clock);
        BtnNext = 1'b0; BtnPrev = 1'b0;
        repeat (5) @(negedge Clock);

        press(2, 2);
        guard = 0;
        while (!(m_auto && m_sel == 2 && m_dwell == DWELL - 1 && ((m_n + 2) % TDIV) == 0) && guard < 300) begin
            @(negedge Clock);
            guard++;
        end
        if (guard >= 300) timeout_fail("align_expiry");
        else press(0, 1);
        repeat (20) @(negedge Clock);

        guard = 0;
        while (!(m_auto && m_sel == 5 && m_dwell == 1) && guard < 300) begin
            @(negedge Clock);
            guard++;
        end
        if (guard >= 300) timeout_fail("align_sel5");
        BtnNext = 1'b1;
        @(negedge Clock);
        Reset = 1'b1; BtnNext = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);

        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) BtnNext = ~BtnNext;
            if ($urandom_range(0, 9) == 0) BtnPrev = ~BtnPrev;
            if ($urandom_range(0, 29) == 0) BtnMode = ~BtnMode;
            Reset = ($urandom_range(0, 199) == 0);
            @(negedge Clock);
        end
        Reset = 1'b0; BtnNext = 1'b0; BtnPrev = 1'b0; BtnMode = 1'b0;
        repeat (3) @(negedge Clock);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
